// File: rtl/traffic_pkg.sv
// Shared types and default sizing for the vehicle detection front end.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2
  } lane_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_WAIT_W          = 8;
  localparam int unsigned DEF_STUCK_CYCLES    = 200;

endpackage

// File: rtl/vehicle_detect_lane.sv
// One direction: sensor synchroniser, debounce, request FSM, wait counter and
// stuck-sensor detection.
module vehicle_detect_lane
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned WAIT_W          = DEF_WAIT_W,
  parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sensor,
  input  logic              i_green,
  output logic              o_detect,
  output logic [WAIT_W-1:0] o_wait,
  output logic              o_fault
);

  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned STUCK_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYCLES - 1);

  logic               sync_q1;
  logic               sync_q2;
  logic               deb_q;
  logic [DB_W-1:0]    db_cnt;
  logic [STUCK_W-1:0] stuck_cnt;
  lane_state_e        state;

  // NOTE: every register here uses <= so the synchroniser stages shift by one
  // flop per edge instead of collapsing into a single wire-through.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      deb_q   <= 1'b0;
      db_cnt  <= '0;
    end else begin
      sync_q1 <= i_sensor;
      sync_q2 <= sync_q1;
      if (sync_q2 == deb_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        deb_q  <= sync_q2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Outputs are registered from the current state, so they trail it by one edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      o_detect <= 1'b0;
      o_wait   <= '0;
    end else begin
      case (state)
        IDLE:    if (deb_q)    state <= PENDING;
        PENDING: if (i_green)  state <= SERVING;
        SERVING: if (!i_green) state <= deb_q ? PENDING : IDLE;
        default: state <= IDLE;
      endcase
      o_detect <= (state != IDLE);
      if (state == PENDING && !i_green) begin
        if (o_wait != '1) o_wait <= o_wait + WAIT_W'(1);
      end else begin
        o_wait <= '0;
      end
    end
  end

  // Fault is sticky and purely informational; the request keeps being driven.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stuck_cnt <= '0;
      o_fault   <= 1'b0;
    end else if (!deb_q || i_green) begin
      stuck_cnt <= '0;
    end else begin
      if (stuck_cnt != STUCK_LAST) stuck_cnt <= stuck_cnt + STUCK_W'(1);
      if (stuck_cnt == STUCK_LAST) o_fault <= 1'b1;
    end
  end

endmodule

// File: rtl/vehicle_detect_ctrl.sv
// Two independent detection lanes producing the NS/EW requests for traffic_light.
module vehicle_detect_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned WAIT_W          = DEF_WAIT_W,
  parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ns_sensor,
  input  logic              i_ew_sensor,
  input  logic              i_ns_green,
  input  logic              i_ew_green,
  output logic              o_ns_vehicle_detect,
  output logic              o_ew_vehicle_detect,
  output logic [WAIT_W-1:0] o_ns_wait,
  output logic [WAIT_W-1:0] o_ew_wait,
  output logic              o_ns_fault,
  output logic              o_ew_fault
);

  vehicle_detect_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .WAIT_W         (WAIT_W),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_ns_lane (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_sensor(i_ns_sensor),
    .i_green (i_ns_green),
    .o_detect(o_ns_vehicle_detect),
    .o_wait  (o_ns_wait),
    .o_fault (o_ns_fault)
  );

  vehicle_detect_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .WAIT_W         (WAIT_W),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_ew_lane (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_sensor(i_ew_sensor),
    .i_green (i_ew_green),
    .o_detect(o_ew_vehicle_detect),
    .o_wait  (o_ew_wait),
    .o_fault (o_ew_fault)
  );

endmodule

// File: tb/tb_vehicle_detect_ctrl.sv
// Directed bench for vehicle_detect_ctrl: one task per scenario, inline checks.
module tb_vehicle_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ns_sensor = 1'b0;
  logic       ew_sensor = 1'b0;
  logic       ns_green = 1'b0;
  logic       ew_green = 1'b0;
  logic       ns_detect, ew_detect, ns_fault, ew_fault;
  logic [7:0] ns_wait, ew_wait;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  vehicle_detect_ctrl dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_ns_sensor        (ns_sensor),
    .i_ew_sensor        (ew_sensor),
    .i_ns_green         (ns_green),
    .i_ew_green         (ew_green),
    .o_ns_vehicle_detect(ns_detect),
    .o_ew_vehicle_detect(ew_detect),
    .o_ns_wait          (ns_wait),
    .o_ew_wait          (ew_wait),
    .o_ns_fault         (ns_fault),
    .o_ew_fault         (ew_fault)
  );

  // Advance one rising edge and settle; inputs changed after this land on the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ns_sensor = 1'b0; ew_sensor = 1'b0; ns_green = 1'b0; ew_green = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    tests_run++;
    if ({ns_detect, ew_detect, ns_fault, ew_fault} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags got %b required 0000", {ns_detect, ew_detect, ns_fault, ew_fault});
    end
    tests_run++;
    if ({ns_wait, ew_wait} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_waits got %h required 0000", {ns_wait, ew_wait});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_clean_arrival();
    do_reset();
    ns_sensor = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      step();
      tests_run++;
      if (ns_detect !== (e >= 7)) begin
        tests_failed++;
        $display("FAIL arrival_ns_detect edge %0d got %b required %b", e, ns_detect, (e >= 7));
      end
      tests_run++;
      if (ns_wait !== ((e >= 7) ? 8'(e - 6) : 8'd0)) begin
        tests_failed++;
        $display("FAIL arrival_ns_wait edge %0d got %0d required %0d", e, ns_wait, (e >= 7) ? e - 6 : 0);
      end
      tests_run++;
      if (ew_detect !== 1'b0 || ew_wait !== 8'd0) begin
        tests_failed++;
        $display("FAIL arrival_ew_idle edge %0d got %b/%0d required 0/0", e, ew_detect, ew_wait);
      end
    end
  endtask

  task automatic test_glitch_reject();
    do_reset();
    ew_sensor = 1'b1;
    step(); step(); step();
    ew_sensor = 1'b0;
    for (int e = 3; e <= 14; e++) begin
      step();
      tests_run++;
      if (ew_detect !== 1'b0 || ew_wait !== 8'd0) begin
        tests_failed++;
        $display("FAIL glitch_ew edge %0d got %b/%0d required 0/0", e, ew_detect, ew_wait);
      end
    end
  endtask

  task automatic test_serve_clear();
    do_reset();
    ns_sensor = 1'b1;
    repeat (27) step();
    tests_run++;
    if (ns_wait !== 8'd20) begin
      tests_failed++;
      $display("FAIL serve_pre_wait got %0d required 20", ns_wait);
    end
    ns_sensor = 1'b0;
    ns_green  = 1'b1;
    for (int e = 27; e <= 36; e++) begin
      step();
      tests_run++;
      if (ns_detect !== 1'b1 || ns_wait !== 8'd0) begin
        tests_failed++;
        $display("FAIL serve_green edge %0d got %b/%0d required 1/0", e, ns_detect, ns_wait);
      end
    end
    ns_green = 1'b0;
    step();
    tests_run++;
    if (ns_detect !== 1'b1) begin
      tests_failed++;
      $display("FAIL serve_drop_edge got %b required 1", ns_detect);
    end
    step();
    tests_run++;
    if (ns_detect !== 1'b0 || ns_wait !== 8'd0) begin
      tests_failed++;
      $display("FAIL serve_cleared got %b/%0d required 0/0", ns_detect, ns_wait);
    end
  endtask

  task automatic test_requeue();
    do_reset();
    ns_sensor = 1'b1;
    repeat (8) step();
    ns_green = 1'b1;
    repeat (3) step();
    tests_run++;
    if (ns_detect !== 1'b1 || ns_wait !== 8'd0) begin
      tests_failed++;
      $display("FAIL requeue_serving got %b/%0d required 1/0", ns_detect, ns_wait);
    end
    ns_green = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      step();
      tests_run++;
      if (ns_detect !== 1'b1 || ns_wait !== 8'(k)) begin
        tests_failed++;
        $display("FAIL requeue_wait step %0d got %b/%0d required 1/%0d", k, ns_detect, ns_wait, k);
      end
    end
  endtask

  task automatic test_saturation_fault();
    do_reset();
    ew_sensor = 1'b1;
    for (int e = 0; e < 300; e++) begin
      step();
      if (e == 204 || e == 205) begin
        tests_run++;
        if (ew_fault !== (e == 205)) begin
          tests_failed++;
          $display("FAIL sat_fault_onset edge %0d got %b required %b", e, ew_fault, (e == 205));
        end
      end
      if (e == 260 || e == 261 || e == 299) begin
        tests_run++;
        if (ew_wait !== ((e == 260) ? 8'd254 : 8'd255)) begin
          tests_failed++;
          $display("FAIL sat_wait edge %0d got %0d required %0d", e, ew_wait, (e == 260) ? 254 : 255);
        end
      end
    end
    ew_sensor = 1'b0;
    repeat (20) step();
    tests_run++;
    if (ew_fault !== 1'b1 || ns_fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_fault_sticky got ew=%b ns=%b required ew=1 ns=0", ew_fault, ns_fault);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (ew_fault !== 1'b0 || ew_wait !== 8'd0) begin
      tests_failed++;
      $display("FAIL sat_fault_reset got %b/%0d required 0/0", ew_fault, ew_wait);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    ns_sensor = 1'b1;
    ew_sensor = 1'b1;
    repeat (10) step();
    tests_run++;
    if (ns_detect !== 1'b1 || ew_detect !== 1'b1 || ns_wait !== 8'd3 || ew_wait !== 8'd3) begin
      tests_failed++;
      $display("FAIL async_pending got %b%b %0d/%0d required 11 3/3", ns_detect, ew_detect, ns_wait, ew_wait);
    end
    #3 rst = 1'b1;
    #1;
    tests_run++;
    if ({ns_detect, ew_detect, ns_fault, ew_fault} !== 4'b0000 || {ns_wait, ew_wait} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL async_clear got %b %h required 0000 0000", {ns_detect, ew_detect, ns_fault, ew_fault}, {ns_wait, ew_wait});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      step();
      if (e >= 6) begin
        tests_run++;
        if (ns_detect !== (e == 7) || ew_detect !== (e == 7)) begin
          tests_failed++;
          $display("FAIL async_redetect edge %0d got %b%b required %b%b", e, ns_detect, ew_detect, (e == 7), (e == 7));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_arrival();
    test_glitch_reject();
    test_serve_clear();
    test_requeue();
    test_saturation_fault();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
